// File: rtl/css_mcu0_el2_pkg.sv
// Shared types and constants for the LSU trigger sequencer.
package css_mcu0_el2_pkg;

    localparam int NUM_TRIG = 4;

    typedef enum logic {TSEQ_IDLE, TSEQ_REQ} el2_trig_seq_state_t;

endpackage

// File: rtl/css_mcu0_el2_lsu_trig_cnt.sv
// Per-trigger hit-count threshold register and counter; fire is combinational on the qualified match.
module css_mcu0_el2_lsu_trig_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             eff,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wdata,
    output logic             fire
);

    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_thr;

    // cnt stays strictly below thr, so cnt+1 can never wrap.
    always_comb begin
        at_thr = (thr_q <= CNT_W'(1)) || ((cnt_q + CNT_W'(1)) == thr_q);
        fire   = eff & ~wr_en & at_thr;
        thr_d  = thr_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            thr_d = wdata;
            cnt_d = '0;
        end else if (eff) begin
            cnt_d = at_thr ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            thr_q <= '0;
            cnt_q <= '0;
        end else begin
            thr_q <= thr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/css_mcu0_el2_lsu_trigger_seq.sv
// LSU trigger sequencer: qualifies and chains M-stage matches, applies hit-count thresholds,
// tracks sticky status and presents one held request/ack handshake to dec.
module css_mcu0_el2_lsu_trigger_seq
    import css_mcu0_el2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [NUM_TRIG-1:0] lsu_trig_match_m,
    input  logic                lsu_valid_m,
    input  logic                lsu_flush_m,
    input  logic [1:0]          trig_chain,
    input  logic [NUM_TRIG-1:0] trig_action,
    input  logic                cfg_wr_en,
    input  logic [1:0]          cfg_idx,
    input  logic [CNT_W-1:0]    cfg_wdata,
    input  logic [NUM_TRIG-1:0] hit_clr,
    input  logic                trig_ack,
    output logic                trig_req,
    output logic [NUM_TRIG-1:0] trig_req_hit,
    output logic                trig_req_action,
    output logic [NUM_TRIG-1:0] trig_hit_status,
    output logic                trig_overflow
);

    logic [NUM_TRIG-1:0] q, eff, fire;

    always_comb begin
        q   = lsu_trig_match_m & {NUM_TRIG{lsu_valid_m & ~lsu_flush_m}};
        eff = q;
        for (int p = 0; p < NUM_TRIG/2; p++) begin
            if (trig_chain[p]) begin
                eff[2*p]   = q[2*p] & q[2*p+1];
                eff[2*p+1] = q[2*p] & q[2*p+1];
            end
        end
    end

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_cnt
        css_mcu0_el2_lsu_trig_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_l (rst_l),
            .eff   (eff[i]),
            .wr_en (cfg_wr_en && (cfg_idx == 2'(i))),
            .wdata (cfg_wdata),
            .fire  (fire[i])
        );
    end

    el2_trig_seq_state_t state_q, state_d;
    logic [NUM_TRIG-1:0] hit_q, hit_d, status_q, status_d;
    logic                act_q, act_d, ovf_q, ovf_d, ovf_set;
    logic                any_fire, fire_act;

    always_comb begin
        any_fire = |fire;
        fire_act = |(fire & trig_action);
        state_d  = state_q;
        hit_d    = hit_q;
        act_d    = act_q;
        ovf_set  = 1'b0;
        case (state_q)
            TSEQ_IDLE: begin
                if (any_fire) begin
                    state_d = TSEQ_REQ;
                    hit_d   = fire;
                    act_d   = fire_act;
                end
            end
            TSEQ_REQ: begin
                if (trig_ack && any_fire) begin
                    hit_d = fire;
                    act_d = fire_act;
                end else if (trig_ack) begin
                    state_d = TSEQ_IDLE;
                    hit_d   = '0;
                    act_d   = 1'b0;
                end else if (any_fire) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = TSEQ_IDLE;
        endcase
        // New fires win over same-cycle clears for both status and overflow.
        status_d = (status_q & ~hit_clr) | fire;
        ovf_d    = ovf_set | (ovf_q & ~(|hit_clr));
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= TSEQ_IDLE;
            hit_q    <= '0;
            act_q    <= 1'b0;
            status_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            act_q    <= act_d;
            status_q <= status_d;
            ovf_q    <= ovf_d;
        end
    end

    assign trig_req        = (state_q == TSEQ_REQ);
    assign trig_req_hit    = hit_q;
    assign trig_req_action = act_q;
    assign trig_hit_status = status_q;
    assign trig_overflow   = ovf_q;

endmodule

// File: tb/tb_css_mcu0_el2_lsu_trigger_seq.sv
// Directed plus randomized check of the trigger sequencer against a behavioural model.
module tb_css_mcu0_el2_lsu_trigger_seq;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic [3:0] match, action, clr;
    logic       valid, flush, wr, ack;
    logic [1:0] chain, idx;
    logic [7:0] wdata;
    logic       trig_req, trig_req_action, trig_overflow;
    logic [3:0] trig_req_hit, trig_hit_status;

    css_mcu0_el2_lsu_trigger_seq #(.CNT_W(8)) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .lsu_trig_match_m (match),
        .lsu_valid_m      (valid),
        .lsu_flush_m      (flush),
        .trig_chain       (chain),
        .trig_action      (action),
        .cfg_wr_en        (wr),
        .cfg_idx          (idx),
        .cfg_wdata        (wdata),
        .hit_clr          (clr),
        .trig_ack         (ack),
        .trig_req         (trig_req),
        .trig_req_hit     (trig_req_hit),
        .trig_req_action  (trig_req_action),
        .trig_hit_status  (trig_hit_status),
        .trig_overflow    (trig_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: thresholds/counters as plain integers, request as a flag plus payload.
    int       m_thr [4];
    int       m_cnt [4];
    bit       m_req, m_act, m_ovf;
    bit [3:0] m_hit, m_stat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_thr[i] = 0;
            m_cnt[i] = 0;
        end
        m_req = 0; m_act = 0; m_ovf = 0; m_hit = 0; m_stat = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_req"},  32'(trig_req),        32'(m_req));
        chk({tag, "_hit"},  32'(trig_req_hit),    32'(m_hit));
        chk({tag, "_act"},  32'(trig_req_action), 32'(m_act));
        chk({tag, "_stat"}, 32'(trig_hit_status), 32'(m_stat));
        chk({tag, "_ovf"},  32'(trig_overflow),   32'(m_ovf));
    endtask

    task automatic idle();
        match = 4'b0; valid = 1'b0; flush = 1'b0; wr = 1'b0; clr = 4'b0; ack = 1'b0;
    endtask

    // Advance the model with the current inputs, clock the DUT, then compare.
    task automatic step(input string tag);
        bit [3:0] qv, e, f;
        bit       lost;
        qv = (valid && !flush) ? match : 4'b0;
        e  = qv;
        for (int p = 0; p < 2; p++) begin
            if (chain[p]) begin
                e[2*p]   = qv[2*p] && qv[2*p+1];
                e[2*p+1] = qv[2*p] && qv[2*p+1];
            end
        end
        f = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (wr && idx == 2'(i)) begin
                m_thr[i] = int'(wdata);
                m_cnt[i] = 0;
            end else if (e[i]) begin
                if (m_thr[i] <= 1 || m_cnt[i] + 1 == m_thr[i]) begin
                    f[i] = 1'b1;
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_stat = (m_stat & ~clr) | f;
        lost   = m_req && !ack && (f != 0);
        if (!m_req || ack) begin
            if (f != 0) begin
                m_req = 1; m_hit = f; m_act = |(f & action);
            end else begin
                m_req = 0; m_hit = 0; m_act = 0;
            end
        end
        m_ovf = lost || (m_ovf && clr == 4'b0);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        idle();
        chain = 2'b0; action = 4'b0; idx = 2'b0; wdata = 8'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        chk("rst_req", 32'(trig_req), 32'd0);
        rst_l = 1'b1;

        // threshold 0 fires on the first match, one-cycle latency
        action = 4'b0001;
        wr = 1'b1; idx = 2'd0; wdata = 8'd0; step("t1_cfg");
        idle(); match = 4'b0001; valid = 1'b1; step("t1_m");
        chk("t1_req", 32'(trig_req), 32'd1);
        chk("t1_hit", 32'(trig_req_hit), 32'b0001);
        chk("t1_act", 32'(trig_req_action), 32'd1);
        idle(); ack = 1'b1; step("t1_ack");
        chk("t1_ack_req", 32'(trig_req), 32'd0);

        // threshold 3 fires on the third match only
        idle(); wr = 1'b1; idx = 2'd2; wdata = 8'd3; step("t2_cfg");
        for (int k = 0; k < 3; k++) begin
            idle(); match = 4'b0100; valid = 1'b1; step("t2_m");
            chk("t2_req", 32'(trig_req), (k == 2) ? 32'd1 : 32'd0);
            idle(); step("t2_gap");
        end
        chk("t2_stat", 32'(trig_hit_status[2]), 32'd1);
        idle(); ack = 1'b1; step("t2_ack");
        idle(); match = 4'b0100; valid = 1'b1; step("t2_restart");
        chk("t2_restart_req", 32'(trig_req), 32'd0);

        // chaining and flush
        idle(); clr = 4'hf; step("t3_clr");
        chain = 2'b01;
        idle(); match = 4'b0001; valid = 1'b1; step("t3_half");
        chk("t3_half_req", 32'(trig_req), 32'd0);
        idle(); match = 4'b0011; valid = 1'b1; step("t3_pair");
        chk("t3_pair_req", 32'(trig_req), 32'd1);
        chk("t3_pair_hit", 32'(trig_req_hit), 32'b0011);
        idle(); ack = 1'b1; step("t3_ack");
        idle(); clr = 4'hf; step("t3_clr2");
        idle(); match = 4'b0011; valid = 1'b1; flush = 1'b1; step("t3_flush");
        chk("t3_flush_req", 32'(trig_req), 32'd0);
        chk("t3_flush_stat", 32'(trig_hit_status), 32'd0);

        // debug priority, held request, overflow
        action = 4'b0010;
        idle(); wr = 1'b1; idx = 2'd2; wdata = 8'd0; step("t4_cfg");
        idle(); match = 4'b0011; valid = 1'b1; step("t4_m");
        chk("t4_act", 32'(trig_req_action), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            idle();
            if (c == 3) begin
                match = 4'b1000; valid = 1'b1;
            end
            step("t4_hold");
            chk("t4_hold_req", 32'(trig_req), 32'd1);
            chk("t4_hold_hit", 32'(trig_req_hit), 32'b0011);
        end
        chk("t4_ovf", 32'(trig_overflow), 32'd1);

        // ack with same-cycle fire reloads; set beats clear on status
        idle(); ack = 1'b1; match = 4'b0100; valid = 1'b1; step("t5_reload");
        chk("t5_req", 32'(trig_req), 32'd1);
        chk("t5_hit", 32'(trig_req_hit), 32'b0100);
        idle(); clr = 4'b0100; match = 4'b0100; valid = 1'b1; step("t5_setclr");
        chk("t5_stat2", 32'(trig_hit_status[2]), 32'd1);

        // async reset mid-request
        idle();
        #2 rst_l = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6_req", 32'(trig_req), 32'd0);
        #1 rst_l = 1'b1;
        step("t6_rel1");
        step("t6_rel2");
        chk("t6_norreq", 32'(trig_req), 32'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            match = 4'($urandom);
            valid = ($urandom % 10) < 7;
            flush = ($urandom % 8) == 0;
            if (($urandom % 50) == 0) chain = 2'($urandom);
            action = 4'($urandom);
            wr = ($urandom % 16) == 0;
            idx = 2'($urandom);
            wdata = 8'($urandom % 5);
            clr = (($urandom % 20) == 0) ? 4'($urandom) : 4'b0;
            ack = 1'($urandom);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
